spi_multidevice_dds: RTL and testbench
======================================

Name: spi_multidevice_dds

Overview:
- SPI-slave front end exposing one addressable sub-device: a multi-channel DDS (phase-accumulator square-wave generator).
- Host writes framed byte commands over SPI. Query commands (device id, config) latch a response that the host clocks out in the next frame; an interrupt flags it pending.
- DDS channel outputs drive `out`. Everything runs on the single system clock; SPI pins are oversampled.

Parameters:
- DEVICE_ID, 32'h4D44_0001, value returned by get-id.
- CHANNELS, 4, DDS channel count (equals `out` width).
- PHASE_WIDTH, 64, phase accumulator and frequency code width.
- CLK_HZ, 32'd50_000_000, clk frequency reported in config.

Ports:
- clk  in  1  system clock; all logic, including the DDS.
- reset  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock, mode 0 (idles low, data sampled on rise), async to clk, f_sck ≤ clk/8.
- mosi  in  1  SPI data in, MSB first.
- ncs  in  1  SPI chip select, active low; its high-to-low transition starts a frame.
- miso  out  1  SPI data out; 0 while ncs is high.
- interrupt  out  1  response pending.
- out  out  CHANNELS  DDS outputs.

Behaviour:
- Reset values: miso=0, interrupt=0, out=0, all channels disabled, freq=0, divider=0, accumulators=0, response buffer empty, rx bit count 0.
- Synchronisers: sck, mosi and ncs each pass through a 2-FF synchroniser, followed by edge detect on the synced sck and ncs.
- Frame start (ncs falling edge):
  - Clear rx buffer and bit count; clear interrupt.
  - Load the 120-bit tx shifter from the response register, then mark the response empty.
  - Drive miso with tx[119] no later than 4 clk after ncs falls.
- Synced sck rising edge while ncs low: if bit count < 120, write mosi to rx[119-count] and increment count; bits beyond 120 are discarded.
- Synced sck falling edge while ncs low: shift tx left with 0 fill and drive the new tx[119] on miso within 4 clk. Once the response is exhausted, miso is 0.
- Frame end (ncs rising edge): decode rx, MSB-first bytes B0..B14. The command executes only when the frame length matches exactly; otherwise the frame is ignored.
  - B0 = sub-device address; only 0 is valid, other addresses are ignored.
  - B1=0, 16 bits: get id. Response = DEVICE_ID (32 bits, left-aligned); interrupt=1.
  - B1=1, 16 bits: get config. Response = 120 bits {CHANNELS[7:0], PHASE_WIDTH[7:0], 8'd16, CLK_HZ[31:0], 64'h0}; interrupt=1.
  - B1=3, B2=2, 112 bits: set frequency. B3 = channel, B4..B11 = 64-bit freq code (big-endian), B12..B13 = 16-bit divider.
  - B1=3, B2=5, 40 bits: enable. B3 = channel, B4[0] = enable.
  - A channel index ≥ CHANNELS is ignored.
  - B1=2, other B1/B2 codes, or a wrong length: ignored; response and interrupt unchanged.
- Response lifetime: a response survives until the next frame start. A frame that issues no query leaves the response empty, so the following read returns zeros.
- Reset mid-frame: abort everything; the next ncs falling edge starts a clean frame.
- DDS channel:
  - A prescaler counts 0..divider; when it reaches divider it wraps to 0 and acc <= acc + freq, mod 2^PHASE_WIDTH.
  - divider=0 means an update every clk.
  - Output = acc[MSB] when enabled, registered.
  - Disable: accumulator and prescaler cleared, output 0.
  - A frequency write while enabled takes effect on the next update without clearing the accumulator.

Decomposition:
- Package spi_multidevice_pkg: command codes (CMD_GET_ID=0, CMD_GET_CONFIG=1, CMD_DDS=3), DDS sub-commands (SUB_SET_FREQ=2, SUB_ENABLE=5), frame lengths (16/112/40), RX_BITS=120.
- Sub-module dds_channel: clk, reset, enable, freq, divider, out. Instantiate CHANNELS copies via generate.
- SPI synchroniser, shifters and decoder stay in the top module.

Test Plan:
- Get id: after reset, 16-bit frame of zeros (interrupt goes 1), then 32-bit frame -> miso returns 0x4D440001; interrupt clears at ncs fall.
- Get config: 16-bit frame {00,01}, then 120-bit frame -> 04 40 10 02FAF080 followed by eight 00 bytes. A second read returns all zeros.
- Set frequency: 112-bit frame {00,03,02,00, FFFF000000000000, 0000}, then 40-bit enable {00,03,05,00,01} -> out[0] toggles on its phase MSB, out[3:1] stay 0. Then {..,00} disables -> out[0]=0 within 2 clk.
- Divider: divider=3 with freq=8000_0000_0000_0000 -> out[0] toggles every 4 clk.
- Robustness: 24-bit get-id frame, address B0=1, and channel 7 are each ignored. Asserting reset mid-120-bit read -> miso=0, interrupt=0; next get id works normally.

Source files
------------

// File: rtl/spi_multidevice_pkg.sv
// Shared command codes, frame lengths and receive-buffer geometry for the SPI DDS front end.
package spi_multidevice_pkg;

  typedef enum logic [7:0] {
    CMD_GET_ID     = 8'd0,
    CMD_GET_CONFIG = 8'd1,
    CMD_DDS        = 8'd3
  } cmd_e;

  typedef enum logic [7:0] {
    SUB_SET_FREQ = 8'd2,
    SUB_ENABLE   = 8'd5
  } sub_e;

  localparam int         RX_BITS      = 120;
  localparam logic [6:0] LEN_QUERY    = 7'd16;
  localparam logic [6:0] LEN_SET_FREQ = 7'd112;
  localparam logic [6:0] LEN_ENABLE   = 7'd40;
  localparam logic [6:0] RX_CNT_MAX   = 7'd120;
  localparam logic [6:0] RX_TOP       = 7'd119;

endpackage

// File: rtl/dds_channel.sv
// One phase-accumulator square-wave channel with a programmable update prescaler.
module dds_channel
  import spi_multidevice_pkg::*;
#(
  parameter int PHASE_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] freq,
  input  logic [15:0]            divider,
  output logic                   out
);

  logic [PHASE_WIDTH-1:0] acc_q;
  logic [15:0]            pre_q;
  logic                   out_q;

  // Prescaler gates accumulator updates; disabling parks the channel at phase zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      pre_q <= '0;
      out_q <= 1'b0;
    end else if (!enable) begin
      acc_q <= '0;
      pre_q <= '0;
      out_q <= 1'b0;
    end else begin
      // >= so that lowering the divider below the running count still wraps promptly
      if (pre_q >= divider) begin
        pre_q <= '0;
        acc_q <= acc_q + freq;
      end else begin
        pre_q <= pre_q + 16'd1;
      end
      out_q <= acc_q[PHASE_WIDTH-1];
    end
  end

  assign out = out_q;

endmodule

// File: rtl/spi_multidevice_dds.sv
// SPI mode-0 slave with one addressable sub-device: a bank of DDS square-wave channels.
module spi_multidevice_dds
  import spi_multidevice_pkg::*;
#(
  parameter logic [31:0] DEVICE_ID   = 32'h4D44_0001,
  parameter int          CHANNELS    = 4,
  parameter int          PHASE_WIDTH = 64,
  parameter logic [31:0] CLK_HZ      = 32'd50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                mosi,
  input  logic                ncs,
  output logic                miso,
  output logic                interrupt,
  output logic [CHANNELS-1:0] out
);

  localparam logic [RX_BITS-1:0] CFG_RESP =
    {8'(CHANNELS), 8'(PHASE_WIDTH), 8'd16, CLK_HZ, 64'h0};

  logic [2:0] sck_q;
  logic [2:0] ncs_q;
  logic [1:0] mosi_q;

  logic               frame_q;
  logic [RX_BITS-1:0] rx_q;
  logic [RX_BITS-1:0] tx_q;
  logic [RX_BITS-1:0] resp_q;
  logic [6:0]         cnt_q;
  logic               irq_q;

  logic                   en_q   [CHANNELS];
  logic [PHASE_WIDTH-1:0] freq_q [CHANNELS];
  logic [15:0]            div_q  [CHANNELS];

  logic sck_rise, sck_fall, ncs_fall, ncs_rise;
  logic [7:0] b0, b1, b2, ch;
  logic unused_last_byte;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ncs_fall = ~ncs_q[1] & ncs_q[2];
  assign ncs_rise = ncs_q[1] & ~ncs_q[2];

  assign b0 = rx_q[119:112];
  assign b1 = rx_q[111:104];
  assign b2 = rx_q[103:96];
  assign ch = rx_q[95:88];
  // the final byte carries no field
  assign unused_last_byte = ^rx_q[7:0];

  // Two-stage synchronisers; the third stage of sck/ncs holds the previous value for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= '0;
      ncs_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ncs_q  <= {ncs_q[1:0], ncs};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // Frame capture, response shifting and command decode at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= 1'b0;
      rx_q    <= '0;
      tx_q    <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        en_q[i]   <= 1'b0;
        freq_q[i] <= '0;
        div_q[i]  <= '0;
      end
    end else if (ncs_fall) begin
      frame_q <= 1'b1;
      rx_q    <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      tx_q    <= resp_q;
      resp_q  <= '0;
    end else if (ncs_rise) begin
      frame_q <= 1'b0;
      // frame_q guards against an ncs rise that follows a reset taken mid-frame
      if (frame_q && b0 == 8'd0) begin
        if (cnt_q == LEN_QUERY && b1 == CMD_GET_ID) begin
          resp_q <= {DEVICE_ID, 88'h0};
          irq_q  <= 1'b1;
        end else if (cnt_q == LEN_QUERY && b1 == CMD_GET_CONFIG) begin
          resp_q <= CFG_RESP;
          irq_q  <= 1'b1;
        end else if (b1 == CMD_DDS) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (ch == 8'(i)) begin
              if (cnt_q == LEN_SET_FREQ && b2 == SUB_SET_FREQ) begin
                freq_q[i] <= PHASE_WIDTH'(rx_q[87:24]);
                div_q[i]  <= rx_q[23:8];
              end
              if (cnt_q == LEN_ENABLE && b2 == SUB_ENABLE) begin
                en_q[i] <= rx_q[80];
              end
            end
          end
        end
      end
    end else if (frame_q) begin
      if (sck_rise && cnt_q < RX_CNT_MAX) begin
        rx_q[RX_TOP - cnt_q] <= mosi_q[1];
        cnt_q                <= cnt_q + 7'd1;
      end
      if (sck_fall) begin
        tx_q <= {tx_q[RX_BITS-2:0], 1'b0};
      end
    end
  end

  assign miso      = frame_q & tx_q[RX_BITS-1];
  assign interrupt = irq_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    dds_channel #(
      .PHASE_WIDTH(PHASE_WIDTH)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .enable  (en_q[g]),
      .freq    (freq_q[g]),
      .divider (div_q[g]),
      .out     (out[g])
    );
  end

endmodule

// File: tb/tb_spi_multidevice_dds.sv
// Bench for spi_multidevice_dds: bit-banged SPI host plus a command-level reference model.
module tb_spi_multidevice_dds;

  logic       clk = 1'b0;
  logic       reset, sck, mosi, ncs;
  logic       miso, interrupt;
  logic [3:0] out;

  always #5 clk = ~clk;

  spi_multidevice_dds dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .mosi      (mosi),
    .ncs       (ncs),
    .miso      (miso),
    .interrupt (interrupt),
    .out       (out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: device state at command level
  logic [119:0] m_resp;
  logic         m_irq;
  logic         m_en   [4];
  logic [63:0]  m_freq [4];
  logic [15:0]  m_div  [4];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_resp = '0;
    m_irq  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_en[c]   = 1'b0;
      m_freq[c] = '0;
      m_div[c]  = '0;
    end
  endfunction

  function automatic void model_end(input logic [119:0] bits, input int n);
    logic [7:0] b [15];
    for (int i = 0; i < 15; i++) b[i] = bits[119-8*i -: 8];
    if (b[0] != 8'd0) return;
    if (n == 16 && b[1] == 8'd0) begin
      m_resp = {32'h4D44_0001, 88'h0};
      m_irq  = 1'b1;
    end else if (n == 16 && b[1] == 8'd1) begin
      m_resp = {8'd4, 8'd64, 8'd16, 32'd50_000_000, 64'h0};
      m_irq  = 1'b1;
    end else if (n == 112 && b[1] == 8'd3 && b[2] == 8'd2 && b[3] < 8'd4) begin
      m_freq[b[3]] = {b[4], b[5], b[6], b[7], b[8], b[9], b[10], b[11]};
      m_div[b[3]]  = {b[12], b[13]};
    end else if (n == 40 && b[1] == 8'd3 && b[2] == 8'd5 && b[3] < 8'd4) begin
      m_en[b[3]] = b[4][0];
    end
  endfunction

  function automatic logic [119:0] f_query(input logic [7:0] addr, input logic [7:0] code);
    return {addr, code, 104'h0};
  endfunction

  function automatic logic [119:0] f_freq(input logic [7:0] c, input logic [63:0] f, input logic [15:0] d);
    return {8'h00, 8'h03, 8'h02, c, f, d, 8'h00};
  endfunction

  function automatic logic [119:0] f_enable(input logic [7:0] c, input logic en);
    return {8'h00, 8'h03, 8'h05, c, 7'b0, en, 80'h0};
  endfunction

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (4) @(negedge clk);
    r = miso;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  // full frame: checks the returned bits against the model's pending response, then applies the command
  task automatic xfer(input logic [119:0] tx, input int n, input string tag);
    logic [119:0] rx, exp, ones, mask;
    logic r;
    repeat (8) @(negedge clk);
    exp    = m_resp;
    m_resp = '0;
    m_irq  = 1'b0;
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    check_val({tag, "_irqclr"}, interrupt, 0);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(tx[119-i], r);
      rx[119-i] = r;
    end
    repeat (4) @(negedge clk);
    ncs  = 1'b1;
    mosi = 1'b0;
    ones = '1;
    mask = ~(ones >> n);
    check_val({tag, "_miso"}, rx, exp & mask);
    model_end(tx, n);
  endtask

  task automatic settle(input string tag);
    repeat (8) @(negedge clk);
    check_val({tag, "_irq"}, interrupt, m_irq);
    check_val({tag, "_idle_miso"}, miso, 0);
  endtask

  // records a channel after an enable frame and looks for an alignment matching phase = updates*freq
  task automatic dds_seq(input int c, input string tag);
    logic s [200];
    logic others;
    int   found;
    logic ok;
    logic [63:0] acc;
    others = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      s[t] = out[c];
      for (int k = 0; k < 4; k++) if (k != c) others |= out[k];
    end
    found = -1;
    for (int o = 0; o <= 10 && found < 0; o++) begin
      ok = 1'b1;
      for (int t = 0; t < 200; t++) begin
        if (!m_en[c] || t < o) acc = '0;
        else acc = 64'((t - o) / (int'(m_div[c]) + 1)) * m_freq[c];
        if (s[t] !== acc[63]) ok = 1'b0;
      end
      if (ok) found = o;
    end
    check_val({tag, "_seq"}, found >= 0, 1);
    check_val({tag, "_others"}, others, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    logic [119:0] exp;
    logic         r;
    int           c;
    logic [63:0]  f;
    logic [15:0]  d;

    reset = 1'b1; sck = 1'b0; mosi = 1'b0; ncs = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_miso", miso, 0);
    check_val("rst_irq", interrupt, 0);
    check_val("rst_out", out, 0);

    // get id, then read it back
    xfer(f_query(8'h00, 8'h00), 16, "getid");
    settle("getid");
    xfer('0, 32, "getid_rd");
    settle("getid_rd");

    // get config, full read, then a second read that must be empty
    xfer(f_query(8'h00, 8'h01), 16, "getcfg");
    settle("getcfg");
    xfer('0, 120, "getcfg_rd");
    settle("getcfg_rd");
    xfer('0, 120, "getcfg_rd2");
    settle("getcfg_rd2");

    // frequency + enable on channel 0, then disable
    xfer(f_freq(8'd0, 64'hFFFF_0000_0000_0000, 16'd0), 112, "sf0");
    settle("sf0");
    xfer(f_enable(8'd0, 1'b1), 40, "en0");
    dds_seq(0, "en0");
    xfer(f_enable(8'd0, 1'b0), 40, "dis0");
    repeat (6) @(negedge clk);
    check_val("dis0_out", out, 0);

    // divider 3 with half-scale step: toggles every 4 clk
    xfer(f_freq(8'd0, 64'h8000_0000_0000_0000, 16'd3), 112, "div3");
    xfer(f_enable(8'd0, 1'b1), 40, "div3_en");
    dds_seq(0, "div3");
    xfer(f_enable(8'd0, 1'b0), 40, "div3_dis");
    settle("div3_dis");

    // robustness: wrong length, wrong address, out-of-range channel
    xfer({8'h00, 8'h00, 8'h00, 96'h0}, 24, "len24");
    settle("len24");
    xfer(f_query(8'h01, 8'h00), 16, "addr1");
    settle("addr1");
    xfer('0, 32, "addr1_rd");
    xfer(f_freq(8'd3, 64'h8000_0000_0000_0000, 16'd0), 112, "sf3");
    xfer(f_freq(8'd7, 64'h4000_0000_0000_0000, 16'd0), 112, "sf7");
    xfer(f_enable(8'd7, 1'b1), 40, "en7");
    dds_seq(3, "en7");
    settle("en7");

    // randomized queries and channel programming
    for (int it = 0; it < 5; it++) begin
      xfer(f_query(8'h00, 8'($urandom_range(0, 1))), 16, "rq");
      settle("rq");
      xfer('0, 120, "rq_rd");
      c = $urandom_range(0, 3);
      f = {$urandom, $urandom};
      d = 16'($urandom_range(0, 5));
      xfer(f_freq(8'(c), f, d), 112, "rsf");
      xfer(f_enable(8'(c), 1'b1), 40, "ren");
      dds_seq(c, "rdds");
      xfer(f_enable(8'(c), 1'b0), 40, "rdis");
      settle("rdis");
      check_val("rdis_out", out, 0);
    end

    // reset in the middle of a 120-bit read with a channel running
    xfer(f_freq(8'd1, 64'h8000_0000_0000_0000, 16'd0), 112, "pre_sf1");
    xfer(f_enable(8'd1, 1'b1), 40, "pre_en1");
    xfer(f_query(8'h00, 8'h01), 16, "pre_cfg");
    settle("pre_cfg");
    repeat (8) @(negedge clk);
    m_resp = '0;
    m_irq  = 1'b0;
    ncs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 40; i++) spi_bit(1'b0, r);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_miso", miso, 0);
    check_val("midrst_irq", interrupt, 0);
    check_val("midrst_out", out, 0);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_val("postrst_miso", miso, 0);
    for (int i = 0; i < 10; i++) spi_bit(1'b0, r);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    settle("postrst");
    check_val("postrst_out", out, 0);

    xfer(f_query(8'h00, 8'h00), 16, "getid2");
    settle("getid2");
    xfer('0, 32, "getid2_rd");
    settle("getid2_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
